// File: rtl/apb_logic_unit.sv
// apb_logic_unit: APB3 completer holding two operands and an op-select
// register. It exposes RESULT = f(OP_A, OP_B, CTRL), which is recomputed
// on every PCLK edge.
// Optional macro APB_WAIT_STATE_EN inserts one wait state per transfer.
// When the macro is undefined, PREADY is tied high.
// PRDATA and PSLVERR are combinational from the address decode, so a read
// of RESULT sees the value loaded on the access-phase edge.
module apb_logic_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_A   = ADDR_WIDTH'(32'h0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_OP_B   = ADDR_WIDTH'(32'h4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(32'h8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT = ADDR_WIDTH'(32'hC);

    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [1:0]            ctrl;
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] next_result;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  sel_a;
    logic                  sel_b;
    logic                  sel_ctrl;
    logic                  sel_result;
    logic                  addr_valid;
    logic                  access;
    logic                  wr_en;

`ifdef APB_WAIT_STATE_EN
    logic ready;

    // Ready goes high on the second access cycle and drops after completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready <= 1'b0;
        end else begin
            ready <= PSEL & PENABLE & ~ready;
        end
    end

    assign PREADY = ready;
`else
    assign PREADY = 1'b1;
`endif

    // Exact-match address decode and access-phase qualifiers.
    always_comb begin
        sel_a      = (PADDR == ADDR_OP_A);
        sel_b      = (PADDR == ADDR_OP_B);
        sel_ctrl   = (PADDR == ADDR_CTRL);
        sel_result = (PADDR == ADDR_RESULT);
        addr_valid = sel_a | sel_b | sel_ctrl | sel_result;
        access     = PSEL & PENABLE & ~PRESET;
        wr_en      = access & PREADY & PWRITE;
    end

    // Read mux; CTRL is zero-extended.
    always_comb begin
        rd_data = '0;
        if (sel_a) begin
            rd_data = op_a;
        end else if (sel_b) begin
            rd_data = op_b;
        end else if (sel_ctrl) begin
            rd_data = DATA_WIDTH'(ctrl);
        end else if (sel_result) begin
            rd_data = result;
        end
    end

    // Bus response: data only during read access, error only during access.
    always_comb begin
        PRDATA  = (access && !PWRITE) ? rd_data : '0;
        PSLVERR = access & (~addr_valid | (PWRITE & sel_result));
    end

    // Logic operation selected by CTRL.
    always_comb begin
        next_result = '0;
        case (ctrl)
            2'b01:   next_result = op_a & op_b;
            2'b10:   next_result = op_a | op_b;
            2'b11:   next_result = op_a ^ op_b;
            default: next_result = '0;
        endcase
    end

    // Register file: writes commit on the completing edge; RESULT reloads every edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            op_a   <= '0;
            op_b   <= '0;
            ctrl   <= 2'b00;
            result <= '0;
        end else begin
            result <= next_result;
            if (wr_en) begin
                if (sel_a) begin
                    op_a <= PWDATA;
                end
                if (sel_b) begin
                    op_b <= PWDATA;
                end
                if (sel_ctrl) begin
                    ctrl <= PWDATA[1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_logic_unit.sv
// Scoreboard bench for apb_logic_unit: directed register-map scenarios plus
// randomized transfers checked against a register-level reference model.
// Build with +define+APB_WAIT_STATE_EN to exercise the one-wait-state mode.
module tb_apb_logic_unit;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

`ifdef APB_WAIT_STATE_EN
    localparam int  EXP_WAITS      = 1;
    localparam logic EXP_IDLE_READY = 1'b0;
`else
    localparam int  EXP_WAITS      = 0;
    localparam logic EXP_IDLE_READY = 1'b1;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model state
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [1:0]  m_ctrl = '0;

    apb_logic_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_result();
        case (m_ctrl)
            2'd1:    return m_a & m_b;
            2'd2:    return m_a | m_b;
            2'd3:    return m_a ^ m_b;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        e = 1'b0;
        case (a)
            32'h0:   d = m_a;
            32'h4:   d = m_b;
            32'h8:   d = {30'h0, m_ctrl};
            32'hC:   d = m_result();
            default: begin d = 32'h0; e = 1'b1; end
        endcase
    endtask

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, output logic e);
        e = 1'b0;
        case (a)
            32'h0:   m_a = d;
            32'h4:   m_b = d;
            32'h8:   m_ctrl = d[1:0];
            default: e = 1'b1;
        endcase
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        exp_t x;
        x.d = d;
        x.e = e;
        sb.push_back(x);
    endtask

    // One APB transfer; called right after a posedge(+1), leaves the bus idle-ready
    // so that an immediately following call is a back-to-back transfer.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (!PREADY) begin
            n++;
            if (n > 8) begin
                n_err++;
                $display("FAIL pready_timeout: PREADY stayed 0 for %0d cycles at addr 0x%08h", n, a);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $fatal(1, "transfer timeout");
            end
            @(negedge PCLK);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic exp_e);
        logic e;
        m_write(a, d, e);
        push(32'h0, exp_e);
        xfer(1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_e);
        push(exp_d, exp_e);
        xfer(1'b0, a, 32'h0);
    endtask

    // Monitor: pops the scoreboard on each completing access, checks idle outputs otherwise.
    initial begin : monitor
        int waits;
        exp_t x;
        waits = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                waits = 0;
            end else if (PSEL && PENABLE) begin
                if (!PREADY) begin
                    waits++;
                end else begin
                    check("wait_cycles", 32'(waits), 32'(EXP_WAITS));
                    waits = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_completion", 32'h1, 32'h0);
                    end else begin
                        x = sb.pop_front();
                        check($sformatf("prdata@%0h", PADDR), PRDATA, x.d);
                        check($sformatf("pslverr@%0h", PADDR), 32'(PSLVERR), 32'(x.e));
                    end
                end
            end else begin
                check("idle_prdata", PRDATA, 32'h0);
                check("idle_pslverr_pready", {30'h0, PSLVERR, PREADY}, {31'h0, EXP_IDLE_READY});
            end
        end
    end

    // Stimulus
    initial begin : stim
        logic [31:0] a, d, md;
        logic        me;
        @(negedge PCLK);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_pslverr", 32'(PSLVERR), 32'h0);
        check("reset_pready", 32'(PREADY), 32'(EXP_IDLE_READY));
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        idle(1);

        // reset values
        rd(32'h0, 32'h0, 1'b0);
        rd(32'h4, 32'h0, 1'b0);
        rd(32'h8, 32'h0, 1'b0);
        rd(32'hC, 32'h0, 1'b0);
        idle(1);

        // operand write/readback and operations
        wr(32'h0, 32'hAAAAAAAA, 1'b0);
        wr(32'h4, 32'h0F0F0F0F, 1'b0);
        rd(32'h0, 32'hAAAAAAAA, 1'b0);
        rd(32'h4, 32'h0F0F0F0F, 1'b0);
        wr(32'h8, 32'h1, 1'b0);
        rd(32'h8, 32'h1, 1'b0);
        rd(32'hC, 32'h0A0A0A0A, 1'b0);
        idle(2);
        wr(32'h8, 32'h2, 1'b0);
        rd(32'hC, 32'hAFAFAFAF, 1'b0);
        wr(32'h8, 32'h3, 1'b0);
        rd(32'hC, 32'hA5A5A5A5, 1'b0);
        wr(32'h8, 32'hFFFFFFFD, 1'b0);
        rd(32'h8, 32'h1, 1'b0);
        rd(32'hC, 32'h0A0A0A0A, 1'b0);
        wr(32'h8, 32'h3, 1'b0);

        // errors
        wr(32'hC, 32'hDEADBEEF, 1'b1);
        rd(32'hC, 32'hA5A5A5A5, 1'b0);
        wr(32'h10, 32'h12345678, 1'b1);
        wr(32'h1, 32'h55555555, 1'b1);
        rd(32'h0, 32'hAAAAAAAA, 1'b0);
        rd(32'h4, 32'h0F0F0F0F, 1'b0);
        rd(32'h8, 32'h3, 1'b0);
        rd(32'h14, 32'h0, 1'b1);
        rd(32'h5, 32'h0, 1'b1);
        idle(1);

        // back-to-back with no idle cycles
        wr(32'h0, 32'h12345678, 1'b0);
        wr(32'h4, 32'hFFFFFFFF, 1'b0);
        wr(32'h8, 32'h1, 1'b0);
        rd(32'hC, 32'h12345678, 1'b0);
        wr(32'h8, 32'h2, 1'b0);
        rd(32'hC, 32'hFFFFFFFF, 1'b0);
        wr(32'h8, 32'h3, 1'b0);
        rd(32'hC, 32'hEDCBA987, 1'b0);

        // setup-only cycle must not write
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hCAFEF00D;
        @(posedge PCLK); #1;
        idle(1);
        rd(32'h0, 32'h12345678, 1'b0);
        idle(1);

        // reset in the middle of a write access aborts it
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h0BADBEEF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        #1;
        check("midreset_prdata", PRDATA, 32'h0);
        check("midreset_pslverr", 32'(PSLVERR), 32'h0);
        check("midreset_pready", 32'(PREADY), 32'(EXP_IDLE_READY));
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        m_a = '0; m_b = '0; m_ctrl = '0;
        rd(32'h0, 32'h0, 1'b0);
        rd(32'h4, 32'h0, 1'b0);
        rd(32'h8, 32'h0, 1'b0);
        rd(32'hC, 32'h0, 1'b0);

        // wait-state AND repeat after reset
        wr(32'h0, 32'hAAAAAAAA, 1'b0);
        wr(32'h4, 32'h0F0F0F0F, 1'b0);
        wr(32'h8, 32'h1, 1'b0);
        rd(32'hC, 32'h0A0A0A0A, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                3: a = 32'hC;
                4: a = 32'h10;
                5: a = 32'h14;
                6: a = 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 3));
                default: a = $urandom;
            endcase
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                m_write(a, d, me);
                push(32'h0, me);
                xfer(1'b1, a, d);
            end else begin
                m_read(a, md, me);
                push(md, me);
                xfer(1'b0, a, 32'h0);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_logic_unit.md
Name: apb_logic_unit

Overview:
- APB3 completer peripheral providing two operand registers, a control register selecting a bitwise logic operation (AND/OR/XOR), and a read-only result register.
- Sits on the peripheral APB bus behind an APB requester.
- Sole clock is PCLK.

Parameters:
- ADDR_WIDTH, 32, width of PADDR.
- DATA_WIDTH, 32, width of PWDATA/PRDATA, operands and result.

Ports:
- PCLK  input  1  bus clock; all state changes on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  transfer error.

Behaviour:
- Register map (exact PADDR match required; all other addresses, including unaligned ones, are invalid):
  - 0x0 OP_A: RW.
  - 0x4 OP_B: RW.
  - 0x8 CTRL: RW, bits[1:0] stored, upper bits read 0.
  - 0xC RESULT: RO.
- PRESET asserted: OP_A, OP_B, CTRL and RESULT clear to 0 immediately. PRDATA=0, PSLVERR=0. PREADY=1 (macro off).
- Reset asserted mid-transfer aborts the transfer; no register is written.
- Transfer phases:
  - Setup phase: PSEL=1, PENABLE=0.
  - Access phase: PSEL=1, PENABLE=1.
  - Transfer completes on the rising edge where PSEL&PENABLE&PREADY.
- Write commit: at the completing edge, PWDATA is written to the addressed RW register. CTRL takes PWDATA[1:0].
- Write to 0xC: register unchanged, PSLVERR=1 during the access phase.
- Write to an invalid address: no state change, PSLVERR=1.
- Read: during the access phase PRDATA = addressed register, zero-extended where narrower. Invalid address gives PRDATA=0 and PSLVERR=1. PRDATA=0 outside read access phases.
- PSLVERR is asserted only while PSEL&PENABLE, otherwise 0. It is combinational from the address decode.
- RESULT register is reloaded on every PCLK edge from the current OP_A, OP_B and CTRL:
  - CTRL=00: RESULT = 0.
  - CTRL=01: RESULT = OP_A & OP_B.
  - CTRL=10: RESULT = OP_A | OP_B.
  - CTRL=11: RESULT = OP_A ^ OP_B.
- RESULT is valid one cycle after any operand/CTRL write. Any subsequent APB read of 0xC therefore returns the updated value, since every transfer takes at least 2 cycles.
- PREADY=1 constantly (zero wait states) unless the optional feature is enabled.
- Back-to-back transfers (setup immediately after access) must work without idle cycles.
- PSEL=0 or a setup-only cycle causes no state change.

Optional Feature:
- Macro APB_WAIT_STATE_EN.
- When defined:
  - PREADY is driven low for exactly the first access-phase cycle of each transfer and high on the second, giving one wait state.
  - Writes commit and PSLVERR/PRDATA are sampled only on the PREADY=1 edge.
  - PREADY returns to 0 after completion and is 0 during reset.
- When undefined, PREADY is tied to 1 and transfers complete in 2 cycles.

Test Plan:
- Reset, then read 0x0, 0x4, 0x8, 0xC -> all return 0x00000000, PSLVERR=0.
- Write 0x0=0xAAAAAAAA and 0x4=0x0F0F0F0F, read back -> 0xAAAAAAAA, 0x0F0F0F0F.
- With those operands, write CTRL=1, read 0x8 -> 0x1, read 0xC -> 0x0A0A0A0A. Then CTRL=2 gives 0xAFAFAFAF, and CTRL=3 gives 0xA5A5A5A5.
- Write 0xC=0xDEADBEEF -> PSLVERR=1, RESULT unchanged. Write 0x10=0x12345678 -> PSLVERR=1, no register changes. Read 0x14 -> PRDATA=0, PSLVERR=1.
- Back-to-back: OP_A=0x12345678, OP_B=0xFFFFFFFF. CTRL 1/2/3 read 0xC -> 0x12345678, 0xFFFFFFFF, 0xEDCBA987.
- After activity, pulse PRESET for one cycle, then read all four registers -> 0. With APB_WAIT_STATE_EN, repeat the AND test and check PREADY is low for exactly one access cycle per transfer.
